// File: rtl/udp_pkg.sv
// Shared UDP framing constants, output state encoding and header byte helper.
package udp_pkg;

    localparam int          UDP_HDR_LEN      = 8;
    localparam logic [15:0] UDP_CSUM_NONE    = 16'h0000;
    localparam logic [15:0] UDP_DEFAULT_PORT = 16'd1234;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY
    } tx_state_t;

    // Header byte idx (0..7) for a datagram carrying len payload bytes.
    function automatic logic [7:0] udp_hdr_byte(input logic [15:0] src,
                                                input logic [15:0] dst,
                                                input logic [15:0] len,
                                                input logic [2:0]  idx);
        logic [15:0] ulen;
        ulen = len + 16'(UDP_HDR_LEN);
        case (idx)
            3'd0:    return src[15:8];
            3'd1:    return src[7:0];
            3'd2:    return dst[15:8];
            3'd3:    return dst[7:0];
            3'd4:    return ulen[15:8];
            3'd5:    return ulen[7:0];
            3'd6:    return UDP_CSUM_NONE[15:8];
            default: return UDP_CSUM_NONE[7:0];
        endcase
    endfunction

endpackage

// File: rtl/udp_pkt_buffer.sv
// Payload store: simple dual-port byte RAM, one write and one read port.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; callers guarantee address safety.
module udp_pkt_buffer #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: stores each payload whole, then emits it behind an 8-byte UDP header.
// Latency: first header byte valid 2 cycles after the input tlast cycle; 1 byte/cycle after that.
// Backpressure: tready_out drops on buffer or length-queue full; output holds while tready_in is low.
module udp_tx_framer
    import udp_pkg::*;
#(
    parameter logic [15:0] SRC_PORT    = UDP_DEFAULT_PORT,
    parameter logic [15:0] DST_PORT    = UDP_DEFAULT_PORT,
    parameter int          MAX_PAYLOAD = 1472,
    parameter int          BUF_AW      = 11,
    parameter int          LEN_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] udp_axis_tdata_in,
    input  logic       udp_axis_tvalid_in,
    input  logic       udp_axis_tlast_in,
    output logic       udp_axis_tready_out,
    output logic [7:0] udp_axis_tdata_out,
    output logic       udp_axis_tvalid_out,
    output logic       udp_axis_tlast_out,
    input  logic       udp_axis_tready_in,
    output logic       pkt_drop
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
    localparam int          LQ_AW   = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
    localparam int          LQ_CW   = $clog2(LEN_DEPTH + 1);

    function automatic logic [LQ_AW-1:0] lq_inc(input logic [LQ_AW-1:0] p);
        return (p == LQ_AW'(LEN_DEPTH - 1)) ? '0 : p + LQ_AW'(1);
    endfunction

    // Pointers carry one extra bit so a full buffer differs from an empty one.
    logic [BUF_AW:0]   wr_ptr, wr_commit, rd_ptr, used;
    logic [BUF_AW-1:0] fe_ptr;
    logic [15:0]       in_cnt, len_r, pay_left, fe_left;
    logic              rdy_en, in_xfer, wr_en, push, drop;

    logic [15:0]       lq_mem [LEN_DEPTH];
    logic [LQ_AW-1:0]  lq_wp, lq_rp;
    logic [LQ_CW-1:0]  lq_cnt;
    logic              pop;

    tx_state_t         state, state_nxt;
    logic [2:0]        hdr_cnt, hdr_idx;
    logic              ld_hdr, ld_pay, hs, issue;
    logic              pf_vld, ram_vld, head_vld;
    logic [7:0]        pf_dat, ram_dat, head_dat;

    assign used                = wr_ptr - rd_ptr;
    assign udp_axis_tready_out = rdy_en && !used[BUF_AW] && (lq_cnt != LQ_CW'(LEN_DEPTH));
    assign in_xfer             = udp_axis_tvalid_in && udp_axis_tready_out;
    assign wr_en               = in_xfer && (in_cnt < MAX_LEN);
    assign push                = wr_en && udp_axis_tlast_in;
    assign drop                = in_xfer && udp_axis_tlast_in && (in_cnt >= MAX_LEN);

    udp_pkt_buffer #(.AW(BUF_AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[BUF_AW-1:0]),
        .wr_dat  (udp_axis_tdata_in),
        .rd_en   (issue),
        .rd_addr (fe_ptr),
        .rd_dat  (ram_dat)
    );

    // Bytes past MAX_PAYLOAD are swallowed; in_cnt saturates so the tlast sees an oversize length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_en    <= 1'b0;
            wr_ptr    <= '0;
            wr_commit <= '0;
            in_cnt    <= '0;
            pkt_drop  <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            pkt_drop <= drop;
            if (drop) begin
                wr_ptr <= wr_commit;
                in_cnt <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + (BUF_AW+1)'(1);
                if (push) begin
                    wr_commit <= wr_ptr + (BUF_AW+1)'(1);
                    in_cnt    <= '0;
                end else begin
                    in_cnt <= in_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) lq_mem[lq_wp] <= in_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lq_wp  <= '0;
            lq_rp  <= '0;
            lq_cnt <= '0;
        end else begin
            if (push) lq_wp <= lq_inc(lq_wp);
            if (pop)  lq_rp <= lq_inc(lq_rp);
            if (push && !pop)      lq_cnt <= lq_cnt + LQ_CW'(1);
            else if (pop && !push) lq_cnt <= lq_cnt - LQ_CW'(1);
        end
    end

    assign hs       = udp_axis_tvalid_out && udp_axis_tready_in;
    assign head_vld = pf_vld || ram_vld;
    assign head_dat = pf_vld ? pf_dat : ram_dat;
    // Read ahead only when the byte now in flight will have somewhere to land.
    assign issue    = (fe_left != 16'd0) && (!head_vld || ld_pay);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ld_hdr    = 1'b0;
        ld_pay    = 1'b0;
        hdr_idx   = hdr_cnt;
        case (state)
            IDLE: begin
                if (lq_cnt != '0) begin
                    pop       = 1'b1;
                    ld_hdr    = 1'b1;
                    hdr_idx   = 3'd0;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    if (hdr_cnt == 3'd7) begin
                        state_nxt = PAY;
                        ld_pay    = head_vld;
                    end else begin
                        ld_hdr  = 1'b1;
                        hdr_idx = hdr_cnt + 3'd1;
                    end
                end
            end
            PAY: begin
                if (hs && udp_axis_tlast_out) begin
                    state_nxt = IDLE;
                end else if ((!udp_axis_tvalid_out || hs) && (pay_left != 16'd0) && head_vld) begin
                    ld_pay = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            hdr_cnt             <= '0;
            len_r               <= '0;
            pay_left            <= '0;
            fe_left             <= '0;
            fe_ptr              <= '0;
            rd_ptr              <= '0;
            pf_vld              <= 1'b0;
            pf_dat              <= '0;
            ram_vld             <= 1'b0;
            udp_axis_tvalid_out <= 1'b0;
            udp_axis_tlast_out  <= 1'b0;
            udp_axis_tdata_out  <= '0;
        end else begin
            state   <= state_nxt;
            ram_vld <= issue;
            if (ram_vld) pf_dat <= ram_dat;
            pf_vld  <= ld_pay ? (pf_vld && ram_vld) : (pf_vld || ram_vld);

            if (pop) begin
                len_r    <= lq_mem[lq_rp];
                pay_left <= lq_mem[lq_rp];
                fe_left  <= lq_mem[lq_rp];
                hdr_cnt  <= '0;
            end else begin
                if (ld_hdr) hdr_cnt <= hdr_idx;
                if (issue) begin
                    fe_left <= fe_left - 16'd1;
                    fe_ptr  <= fe_ptr + BUF_AW'(1);
                end
                if (ld_pay) begin
                    pay_left <= pay_left - 16'd1;
                    rd_ptr   <= rd_ptr + (BUF_AW+1)'(1);
                end
            end

            if (ld_hdr || ld_pay) begin
                udp_axis_tvalid_out <= 1'b1;
                udp_axis_tdata_out  <= ld_hdr ? udp_hdr_byte(SRC_PORT, DST_PORT, len_r, hdr_idx)
                                              : head_dat;
                udp_axis_tlast_out  <= ld_pay && (pay_left == 16'd1);
            end else if (hs) begin
                udp_axis_tvalid_out <= 1'b0;
                udp_axis_tlast_out  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/udp_tx_framer.md
# udp_tx_framer

Transmit-side UDP framer: accepts a raw payload byte stream on an 8-bit AXI-Stream slave, stores each packet whole, and emits it on an 8-bit AXI-Stream master with the 8-byte UDP header prepended. It sits between the application payload source and the IP transmit path. It is the counterpart of the UDP receive/loopback path.

## Interface

Parameters:
- SRC_PORT, 16'd1234: UDP source port inserted in the header.
- DST_PORT, 16'd1234: UDP destination port inserted in the header.
- MAX_PAYLOAD, 1472: maximum payload bytes per packet; longer packets are dropped.
- BUF_AW, 11: payload buffer address width (2^BUF_AW bytes).
- LEN_DEPTH, 4: number of packets whose lengths can be queued.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-high reset.
- udp_axis_tdata_in, in, 8: payload byte.
- udp_axis_tvalid_in, in, 1: payload byte valid.
- udp_axis_tlast_in, in, 1: last payload byte of the packet.
- udp_axis_tready_out, out, 1: block can accept a payload byte.
- udp_axis_tdata_out, out, 8: framed UDP byte (header, then payload).
- udp_axis_tvalid_out, out, 1: output byte valid.
- udp_axis_tlast_out, out, 1: last byte of the UDP datagram.
- udp_axis_tready_in, in, 1: downstream accepts the output byte.
- pkt_drop, out, 1: one-cycle pulse when an oversize packet is discarded.

## Operation

- Input transfer: occurs when tvalid_in and tready_out are both high.
  - tready_out = (buffer free space ≥ 1) AND (length queue not full).
- Input side uses a write pointer wr_ptr and a committed pointer wr_commit, plus an input byte counter in_cnt (16 bits).
  - On a transfer, the byte is written at wr_ptr, wr_ptr increments modulo 2^BUF_AW, and in_cnt increments.
  - On a transfer with tlast, the payload length is in_cnt+1.
    - If the length is ≤ MAX_PAYLOAD: push the length to the length queue, set wr_commit to the new wr_ptr, and clear in_cnt.
- Oversize packet: once in_cnt reaches MAX_PAYLOAD, further bytes of that packet are accepted but not written.
  - On its tlast: wr_ptr rewinds to wr_commit, in_cnt clears, and pkt_drop pulses.
- Free space is computed against rd_ptr, the read pointer. Committed bytes are never overwritten.
- Output FSM states: IDLE, HDR, PAY.
  - IDLE → HDR when the length queue is not empty. The length is popped into len_r; hdr_cnt = 0.
  - HDR: emits 8 header bytes in this order:
    - SRC_PORT[15:8], SRC_PORT[7:0]
    - DST_PORT[15:8], DST_PORT[7:0]
    - (len_r+8)[15:8], (len_r+8)[7:0]
    - 0x00, 0x00 (checksum disabled, per IPv4 UDP).
    - hdr_cnt advances on each output handshake. After byte 7 is accepted, go to PAY with pay_cnt = len_r.
  - PAY: reads buffer bytes at rd_ptr. On each handshake, rd_ptr increments and pay_cnt decrements.
    - tlast_out is asserted when pay_cnt == 1.
    - When that byte is accepted, go to IDLE.
- Output stage is a registered AXI-Stream source.
  - Once tvalid_out is high, tdata_out and tlast_out are held stable until tready_in is high.
  - The buffer RAM has a 1-cycle read latency. A prefetch register keeps one byte ahead so the PAY phase sustains 1 byte/cycle when tready_in is held high.
- Header length arithmetic is 16-bit, with len_r ≤ MAX_PAYLOAD. No wrap is possible with the default parameters.

## Timing

- Reset values:
  - tvalid_out = 0, tlast_out = 0, tdata_out = 0x00, pkt_drop = 0.
  - tready_out = 0 while reset is asserted, and 1 from the first clock after release.
  - All pointers, counters and the length queue are cleared; FSM = IDLE.
- Latency: the first header byte has tvalid_out high 2 cycles after the clock edge that accepts the input tlast.
  - Edge 1: length pushed. Edge 2: length popped and the HDR byte registered.
- Throughput:
  - Back-to-back packets: the header of packet N+1 follows the last byte of packet N after one IDLE cycle.
  - Input and output run concurrently, so packet N+1 can be written while packet N is being emitted.
- Simultaneous length push and pop in the same cycle are both honoured, and the queue count is unchanged.
- Buffer full: tready_out drops in the same cycle the free space reaches 0. It rises in the cycle after rd_ptr advances.
- Reset mid-packet (either side): the partial packet is discarded, tvalid_out falls asynchronously, and no tlast is emitted.
- tready_in low for any number of cycles: outputs are frozen; no byte is lost or duplicated.

## Structure

- Shared package udp_pkg:
  - UDP_HDR_LEN = 8, UDP_CSUM_NONE = 16'h0000.
  - The output FSM state enum (IDLE/HDR/PAY).
  - The default port constants.
- Sub-module udp_pkt_buffer: single-clock simple dual-port RAM, 8 bits × 2^BUF_AW, with 1-cycle registered read.
- The length queue is a small register FIFO kept inside udp_tx_framer.

## Test plan

- One 4-byte payload (AA BB CC DD), tready_in = 1:
  - Output is 04 D2 04 D2 00 0C 00 00 AA BB CC DD, with tlast on DD.
  - First tvalid_out occurs 2 cycles after the input tlast.
- Three back-to-back 64-byte packets, input and output streaming:
  - Three datagrams, each with length field 0x0048.
  - Exactly one idle cycle between datagrams; payload order preserved.
- A 1473-byte packet, then a 10-byte packet:
  - pkt_drop pulses once.
  - Only the 10-byte datagram appears (length field 0x0012).
  - Buffer occupancy is back to 0 afterwards.
- tready_in toggled pseudo-randomly during a 100-byte packet: output bytes match the input exactly, with stable data while stalled.
- Fill the buffer with tready_in = 0, using packets of 1472 bytes:
  - tready_out falls when either the buffer or the length queue fills.
  - After tready_in = 1, all stored packets drain intact.
- Assert reset mid-payload:
  - All outputs go to their reset values immediately.
  - The next packet after release is framed correctly.
